// File: rtl/dmem_lsu_responder.sv
// Byte-addressed little-endian data memory answering the LSU load/store handshake.
// Optional DMEM_STATS_EN adds saturating load/store/error counters.
module dmem_lsu_responder #(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] load_count,
  output logic [31:0] store_count,
  output logic [31:0] err_count
`endif
);

  localparam int         AW       = $clog2(DEPTH_BYTES);
  localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   cap, live, acc;
  logic [2:0] cnt;
  logic [7:0] mem [DEPTH_BYTES];

  logic accept, do_acc, rsp_done;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        acc_err;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]  b0, b1, b2, b3;
  logic        sext;
  logic [31:0] ld_data;

  assign live = {req_we, req_size, req_unsigned, req_addr, req_wdata};
  // With zero wait states the access happens on the accept edge, so use the live request.
  assign acc  = (state == IDLE) ? live : cap;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    do_acc    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt = RESP;
            do_acc    = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = RESP;
          do_acc    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (acc.size)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
  end

  // 33-bit end address so requests near 2^32 cannot wrap into range.
  assign end_addr = {1'b0, acc.addr} + 33'(nbytes);
  assign acc_err  = (acc.size == 2'b11)
                  | ((acc.size == 2'b01) & acc.addr[0])
                  | ((acc.size == 2'b10) & (|acc.addr[1:0]))
                  | (end_addr > 33'(DEPTH_BYTES));

  assign idx0 = acc.addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];
  assign sext = ~acc.uns;

  always_comb begin
    case (acc.size)
      2'b00:   ld_data = {{24{sext & b0[7]}}, b0};
      2'b01:   ld_data = {{16{sext & b1[7]}}, b1, b0};
      default: ld_data = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap <= live;
        cnt <= CNT_INIT;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (do_acc) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc.we) ? 32'd0 : ld_data;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Storage is never reset; the reset term keeps an abandoned request from writing.
  always_ff @(posedge clk) begin
    if (reset && do_acc && acc.we && !acc_err) begin
      mem[idx0] <= acc.wdata[7:0];
      if (acc.size != 2'b00) mem[idx1] <= acc.wdata[15:8];
      if (acc.size == 2'b10) begin
        mem[idx2] <= acc.wdata[23:16];
        mem[idx3] <= acc.wdata[31:24];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_count  <= '0;
      store_count <= '0;
      err_count   <= '0;
    end else if (rsp_done) begin
      if (rsp_err) begin
        if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
      end else if (cap.we) begin
        if (store_count != 32'hFFFF_FFFF) store_count <= store_count + 32'd1;
      end else begin
        if (load_count != 32'hFFFF_FFFF) load_count <= load_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_lsu_responder.sv
// Directed bench for dmem_lsu_responder: LATENCY=1 main instance, LATENCY=3 instance for reset abort.
module tb_dmem_lsu_responder;
  logic        clk = 1'b0;
  logic        reset, reset3;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_valid3, req_we3, req_unsigned3, rsp_ready3;
  logic [1:0]  req_size3;
  logic [31:0] req_addr3, req_wdata3;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;
`ifdef DMEM_STATS_EN
  logic [31:0] load_count, store_count, err_count;
  logic [31:0] load_count3, store_count3, err_count3;
`endif

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  dmem_lsu_responder #(.DEPTH_BYTES(128), .LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
    , .load_count(load_count), .store_count(store_count), .err_count(err_count)
`endif
  );

  dmem_lsu_responder #(.DEPTH_BYTES(128), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we3), .req_size(req_size3), .req_unsigned(req_unsigned3),
    .req_addr(req_addr3), .req_wdata(req_wdata3), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
`ifdef DMEM_STATS_EN
    , .load_count(load_count3), .store_count(store_count3), .err_count(err_count3)
`endif
  );

  // edges counts rising edges from the accept edge (inclusive) to rsp_valid seen high.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int edges);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b1;
    @(posedge clk); edges = 1; #1 req_valid = 1'b0;
    while (!rsp_valid && edges < 20) begin @(posedge clk); edges++; #1; end
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic do_req3(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic er, output int edges);
    @(negedge clk);
    req_valid3 = 1'b1; req_we3 = we; req_size3 = sz; req_unsigned3 = 1'b0;
    req_addr3 = a; req_wdata3 = wd; rsp_ready3 = 1'b1;
    @(posedge clk); edges = 1; #1 req_valid3 = 1'b0;
    while (!rsp_valid3 && edges < 20) begin @(posedge clk); edges++; #1; end
    er = rsp_err3;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; reset3 = 1'b0;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid3 = 0; req_we3 = 0; req_size3 = 0; req_unsigned3 = 0; req_addr3 = 0; req_wdata3 = 0; rsp_ready3 = 0;
    #12;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b0, 1'b0, 32'd0, 1'b1})
      $display("FAIL reset_state: got v=%b e=%b d=%h rdy=%b want v=0 e=0 d=0 rdy=1", rsp_valid, rsp_err, rsp_rdata, req_ready);
    else pass++;
    @(negedge clk); reset = 1'b1; reset3 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL reset_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    else pass++;
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int ed;
    do_req(1'b1, 2'b10, 1'b0, 32'd0, 32'h0000_0007, rd, er, ed);
    total++;
    if ({er, rd} !== {1'b0, 32'd0}) $display("FAIL word_store_rsp: got e=%b d=%h want e=0 d=0", er, rd);
    else pass++;
    total++;
    if ({u_dut.mem[3], u_dut.mem[2], u_dut.mem[1], u_dut.mem[0]} !== 32'h0000_0007)
      $display("FAIL word_store_mem: got %h%h%h%h want 00000007", u_dut.mem[3], u_dut.mem[2], u_dut.mem[1], u_dut.mem[0]);
    else pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, rd, er, ed);
    total++;
    if ({er, rd} !== {1'b0, 32'h0000_0007}) $display("FAIL word_load: got e=%b d=%h want e=0 d=00000007", er, rd);
    else pass++;
    total++;
    if (ed !== 2) $display("FAIL word_latency: got %0d edges want 2", ed);
    else pass++;
  endtask

  task automatic test_byte_ext;
    logic [31:0] rd; logic er; int ed;
    logic [7:0] m4, m6;
    m4 = u_dut.mem[4]; m6 = u_dut.mem[6];
    do_req(1'b1, 2'b00, 1'b0, 32'd5, 32'h1234_5680, rd, er, ed);
    total++;
    if ({u_dut.mem[6], u_dut.mem[5], u_dut.mem[4], er} !== {m6, 8'h80, m4, 1'b0})
      $display("FAIL byte_store: got %h %h %h e=%b want %h 80 %h e=0", u_dut.mem[6], u_dut.mem[5], u_dut.mem[4], er, m6, m4);
    else pass++;
    do_req(1'b0, 2'b00, 1'b0, 32'd5, 32'd0, rd, er, ed);
    total++;
    if (rd !== 32'hFFFF_FF80) $display("FAIL byte_signed: got %h want ffffff80", rd);
    else pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'd5, 32'd0, rd, er, ed);
    total++;
    if (rd !== 32'h0000_0080) $display("FAIL byte_unsigned: got %h want 00000080", rd);
    else pass++;
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int ed;
    logic [7:0] m22;
    m22 = u_dut.mem[22];
    do_req(1'b1, 2'b01, 1'b0, 32'd20, 32'h1234_CAFE, rd, er, ed);
    total++;
    if ({u_dut.mem[22], u_dut.mem[21], u_dut.mem[20]} !== {m22, 8'hCA, 8'hFE})
      $display("FAIL half_store: got %h %h %h want %h ca fe", u_dut.mem[22], u_dut.mem[21], u_dut.mem[20], m22);
    else pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'd20, 32'd0, rd, er, ed);
    total++;
    if (rd !== 32'hFFFF_CAFE) $display("FAIL half_signed: got %h want ffffcafe", rd);
    else pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'd20, 32'd0, rd, er, ed);
    total++;
    if (rd !== 32'h0000_CAFE) $display("FAIL half_unsigned: got %h want 0000cafe", rd);
    else pass++;
    do_req(1'b0, 2'b10, 1'b1, 32'd0, 32'd0, rd, er, ed);
    total++;
    if (rd !== 32'h0000_0007) $display("FAIL word_ignores_unsigned: got %h want 00000007", rd);
    else pass++;
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int ed; int diffs;
    logic [7:0] snap [128];
    for (int i = 0; i < 128; i++) snap[i] = u_dut.mem[i];
    do_req(1'b1, 2'b01, 1'b0, 32'd3, 32'hFFFF_FFFF, rd, er, ed);
    total++;
    if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL half_misaligned: got e=%b d=%h want e=1 d=0", er, rd);
    else pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'd126, 32'd0, rd, er, ed);
    total++;
    if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL word_misaligned_126: got e=%b d=%h want e=1 d=0", er, rd);
    else pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'd0, rd, er, ed);
    total++;
    if ({er, rd} !== {1'b1, 32'd0}) $display("FAIL word_wrap_addr: got e=%b d=%h want e=1 d=0", er, rd);
    else pass++;
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, rd, er, ed);
    total++;
    if (er !== 1'b1) $display("FAIL store_wrap_addr: got e=%b want e=1", er);
    else pass++;
    do_req(1'b1, 2'b11, 1'b0, 32'd0, 32'hA5A5_A5A5, rd, er, ed);
    total++;
    if (er !== 1'b1) $display("FAIL illegal_size: got e=%b want e=1", er);
    else pass++;
    do_req(1'b1, 2'b00, 1'b0, 32'd128, 32'h0000_0055, rd, er, ed);
    total++;
    if (er !== 1'b1) $display("FAIL byte_out_of_range: got e=%b want e=1", er);
    else pass++;
    diffs = 0;
    for (int i = 0; i < 128; i++) if (u_dut.mem[i] !== snap[i]) diffs++;
    total++;
    if (diffs !== 0) $display("FAIL err_mem_unchanged: got %0d changed bytes want 0", diffs);
    else pass++;
    do_req(1'b1, 2'b10, 1'b0, 32'd124, 32'h0102_0304, rd, er, ed);
    total++;
    if (er !== 1'b0) $display("FAIL word_top_boundary: got e=%b want e=0", er);
    else pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'd127, 32'd0, rd, er, ed);
    total++;
    if ({er, rd} !== {1'b0, 32'h0000_0001}) $display("FAIL byte_last: got e=%b d=%h want e=0 d=00000001", er, rd);
    else pass++;
  endtask

  task automatic test_backpressure;
    int ed;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    @(posedge clk); ed = 1; #1 req_valid = 1'b0;
    while (!rsp_valid && ed < 20) begin @(posedge clk); ed++; #1; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b1, 1'b0, 32'h0000_0007, 1'b0})
        $display("FAIL backpressure_hold[%0d]: got v=%b e=%b d=%h rdy=%b want v=1 e=0 d=00000007 rdy=0",
                 c, rsp_valid, rsp_err, rsp_rdata, req_ready);
      else pass++;
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, req_ready} !== 2'b01)
      $display("FAIL backpressure_release: got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    else pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int ed;
    do_req(1'b1, 2'b00, 1'b0, 32'd40, 32'h0000_005A, rd, er, ed);
    do_req(1'b0, 2'b00, 1'b1, 32'd40, 32'd0, rd, er, ed);
    total++;
    if ({er, rd, ed} !== {1'b0, 32'h0000_005A, 32'd2})
      $display("FAIL back_to_back: got e=%b d=%h edges=%0d want e=0 d=0000005a edges=2", er, rd, ed);
    else pass++;
  endtask

  task automatic test_reset_mid;
    logic er; int ed;
    do_req3(1'b1, 2'b10, 32'd8, 32'h1122_3344, er, ed);
    total++;
    if ({er, ed} !== {1'b0, 32'd4}) $display("FAIL lat3_store: got e=%b edges=%0d want e=0 edges=4", er, ed);
    else pass++;
    @(negedge clk);
    req_valid3 = 1'b1; req_we3 = 1'b1; req_size3 = 2'b10; req_addr3 = 32'd8; req_wdata3 = 32'hDEAD_BEEF;
    @(posedge clk); #1 req_valid3 = 1'b0;
    @(posedge clk);
    @(negedge clk); reset3 = 1'b0;
    #1;
    total++;
    if ({rsp_valid3, req_ready3} !== 2'b01)
      $display("FAIL mid_reset_async: got v=%b rdy=%b want v=0 rdy=1", rsp_valid3, req_ready3);
    else pass++;
    @(posedge clk);
    @(negedge clk); reset3 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid3, req_ready3} !== 2'b01)
      $display("FAIL mid_reset_after: got v=%b rdy=%b want v=0 rdy=1", rsp_valid3, req_ready3);
    else pass++;
    total++;
    if ({u_dut3.mem[11], u_dut3.mem[10], u_dut3.mem[9], u_dut3.mem[8]} !== 32'h1122_3344)
      $display("FAIL mid_reset_mem: got %h%h%h%h want 11223344",
               u_dut3.mem[11], u_dut3.mem[10], u_dut3.mem[9], u_dut3.mem[8]);
    else pass++;
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats;
    logic [31:0] rd; logic er; int ed;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'd0, rd, er, ed);
    do_req(1'b0, 2'b00, 1'b0, 32'd5, 32'd0, rd, er, ed);
    do_req(1'b1, 2'b00, 1'b0, 32'd41, 32'h0000_0011, rd, er, ed);
    do_req(1'b0, 2'b01, 1'b0, 32'd1, 32'd0, rd, er, ed);
    total++;
    if ({load_count, store_count, err_count} !== {32'd2, 32'd1, 32'd1})
      $display("FAIL stats: got l=%0d s=%0d e=%0d want l=2 s=1 e=1", load_count, store_count, err_count);
    else pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_byte_ext();
    test_half();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
